// File: rtl/rc_pkg.sv
// rtl/rc_pkg.sv - shared types and default timeouts for the receive sequencer
package rc_pkg;

    typedef enum logic [2:0] {
        RC_OK      = 3'd0,
        RC_TIMEOUT = 3'd1,
        RC_EOP_ERR = 3'd2,
        RC_CHK_ERR = 3'd3,
        RC_CANCEL  = 3'd4
    } rc_result_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        RECV  = 3'd2,
        CHECK = 3'd3,
        ABORT = 3'd4,
        DONE  = 3'd5
    } rc_seq_state_t;

    localparam int TMR_W_DEF        = 8;
    localparam int ARM_TIMEOUT_DEF  = 200;
    localparam int BODY_TIMEOUT_DEF = 120;
    localparam int CHK_TIMEOUT_DEF  = 16;

endpackage

// File: rtl/rc_sequencer_if.sv
// rtl/rc_sequencer_if.sv - link between the receive sequencer and rc_dpdm
interface rc_sequencer_if;
    logic receive_hshake;
    logic receive_data;
    logic abort;
    logic got_sync;
    logic end_rc_nrzi;
    logic EOP_error;
    logic rc_dpdm_wait;

    modport master (
        output receive_hshake, receive_data, abort,
        input  got_sync, end_rc_nrzi, EOP_error, rc_dpdm_wait
    );

    modport slave (
        input  receive_hshake, receive_data, abort,
        output got_sync, end_rc_nrzi, EOP_error, rc_dpdm_wait
    );
endinterface

// File: rtl/rc_watchdog.sv
// rtl/rc_watchdog.sv - clearable up-counter with terminal-count compare
module rc_watchdog #(
    parameter int TMR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [TMR_W-1:0] tc_value,
    output logic [TMR_W-1:0] count,
    output logic             tc
);
    logic [TMR_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + TMR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign tc    = (count_q == tc_value);
endmodule

// File: rtl/rc_sequencer.sv
// rtl/rc_sequencer.sv - receive-side sequencer: holds receive_* levels, supervises
// sync/body/check with a watchdog, aborts rc_dpdm and reports one result per request.
module rc_sequencer
    import rc_pkg::*;
#(
    parameter int               TMR_W        = TMR_W_DEF,
    parameter logic [TMR_W-1:0] ARM_TIMEOUT  = TMR_W'(ARM_TIMEOUT_DEF),
    parameter logic [TMR_W-1:0] BODY_TIMEOUT = TMR_W'(BODY_TIMEOUT_DEF),
    parameter logic [TMR_W-1:0] CHK_TIMEOUT  = TMR_W'(CHK_TIMEOUT_DEF)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_hshake,
    input  logic                  req_data,
    input  logic                  cancel,
    input  logic                  clr_stats,
    input  logic                  chk_valid,
    input  logic                  chk_ok,
    rc_sequencer_if.master        dpdm,
    output logic                  busy,
    output logic                  done,
    output rc_result_t            result,
    output logic [7:0]            fail_count
);
    rc_seq_state_t    state_q, state_d;
    rc_result_t       code_q, code_d;
    logic             hs_q, hs_d;
    logic             seen_q, seen_d;
    logic             ok_q, ok_d;
    logic [7:0]       fail_q, fail_d;
    logic             timer_clr, timer_en, timer_tc;
    logic [TMR_W-1:0] timer_tc_value, timer_count;

    rc_watchdog #(.TMR_W(TMR_W)) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (timer_clr),
        .en       (timer_en),
        .tc_value (timer_tc_value),
        .count    (timer_count),
        .tc       (timer_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            code_q  <= RC_OK;
            hs_q    <= 1'b0;
            seen_q  <= 1'b0;
            ok_q    <= 1'b0;
            fail_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            hs_q    <= hs_d;
            seen_q  <= seen_d;
            ok_q    <= ok_d;
            fail_q  <= fail_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        hs_d      = hs_q;
        seen_d    = seen_q;
        ok_d      = ok_q;
        timer_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_hshake || req_data) begin
                    state_d   = ARM;
                    hs_d      = req_hshake;
                    seen_d    = 1'b0;
                    ok_d      = 1'b0;
                    timer_clr = 1'b1;
                end
            end
            ARM, RECV, CHECK: begin
                if (state_q == CHECK && chk_valid) begin
                    seen_d = 1'b1;
                    ok_d   = chk_ok;
                end
                // cancel > EOP error > watchdog > normal progress
                if (cancel) begin
                    state_d = ABORT;
                    code_d  = RC_CANCEL;
                end else if (dpdm.EOP_error) begin
                    state_d = ABORT;
                    code_d  = RC_EOP_ERR;
                end else if (timer_tc) begin
                    state_d = ABORT;
                    code_d  = RC_TIMEOUT;
                end else if (state_q == ARM && dpdm.got_sync) begin
                    state_d   = RECV;
                    timer_clr = 1'b1;
                end else if (state_q == RECV && dpdm.end_rc_nrzi) begin
                    state_d   = CHECK;
                    timer_clr = 1'b1;
                end else if (state_q == CHECK && seen_q && dpdm.rc_dpdm_wait) begin
                    state_d = DONE;
                    code_d  = ok_q ? RC_OK : RC_CHK_ERR;
                end
            end
            ABORT:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fail_d = fail_q;
        if (state_q == DONE && code_q != RC_OK && fail_q != 8'hFF) begin
            fail_d = fail_q + 8'd1;
        end
        if (clr_stats) begin
            fail_d = 8'd0;
        end
    end

    always_comb begin
        timer_en = (state_q == ARM) || (state_q == RECV) || (state_q == CHECK);
        case (state_q)
            ARM:     timer_tc_value = ARM_TIMEOUT - TMR_W'(1);
            RECV:    timer_tc_value = BODY_TIMEOUT - TMR_W'(1);
            default: timer_tc_value = CHK_TIMEOUT - TMR_W'(1);
        endcase
    end

    always_comb begin
        dpdm.receive_hshake = ((state_q == ARM) || (state_q == RECV)) && hs_q;
        dpdm.receive_data   = ((state_q == ARM) || (state_q == RECV)) && !hs_q;
        dpdm.abort          = (state_q == ABORT);
        busy                = timer_en || (state_q == ABORT);
        done                = (state_q == DONE);
        result              = (state_q == DONE) ? code_q : RC_OK;
        fail_count          = fail_q;
    end
endmodule

// File: tb/tb_rc_sequencer.sv
// tb/tb_rc_sequencer.sv - directed bench with a phase-level reference model for rc_sequencer
module tb_rc_sequencer;
    import rc_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_hshake = 1'b0, req_data = 1'b0, cancel = 1'b0, clr_stats = 1'b0;
    logic       chk_valid = 1'b0, chk_ok = 1'b0;
    logic       busy, done;
    rc_result_t result;
    logic [7:0] fail_count;

    rc_sequencer_if dpdm_if();

    rc_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_hshake (req_hshake),
        .req_data   (req_data),
        .cancel     (cancel),
        .clr_stats  (clr_stats),
        .chk_valid  (chk_valid),
        .chk_ok     (chk_ok),
        .dpdm       (dpdm_if.master),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .fail_count (fail_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: phases 0 idle, 1 waiting for sync, 2 body, 3 checking, 4 abort, 5 report
    int m_phase, m_age, m_code, m_fails;
    bit m_hs, m_seen, m_ok;

    function automatic int limit_of(input int ph);
        return (ph == 1) ? 200 : (ph == 2) ? 120 : 16;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit prev_seen, prev_ok;
        if (!rst_n) begin
            m_phase = 0; m_age = 0; m_code = 0; m_fails = 0;
            m_hs = 0; m_seen = 0; m_ok = 0;
        end else begin
            prev_seen = m_seen;
            prev_ok   = m_ok;
            case (m_phase)
                0: if (req_hshake || req_data) begin
                    m_phase = 1; m_hs = req_hshake; m_age = 0; m_seen = 0; m_ok = 0;
                end
                1, 2, 3: begin
                    if (m_phase == 3 && chk_valid) begin m_seen = 1; m_ok = chk_ok; end
                    if (cancel) begin m_phase = 4; m_code = 4; end
                    else if (dpdm_if.EOP_error) begin m_phase = 4; m_code = 2; end
                    else if (m_age + 1 == limit_of(m_phase)) begin m_phase = 4; m_code = 1; end
                    else if (m_phase == 1 && dpdm_if.got_sync) begin m_phase = 2; m_age = 0; end
                    else if (m_phase == 2 && dpdm_if.end_rc_nrzi) begin m_phase = 3; m_age = 0; end
                    else if (m_phase == 3 && prev_seen && dpdm_if.rc_dpdm_wait) begin
                        m_phase = 5; m_code = prev_ok ? 0 : 3;
                    end else m_age++;
                end
                4: m_phase = 5;
                default: begin
                    if (m_code != 0 && m_fails < 255) m_fails++;
                    m_phase = 0;
                end
            endcase
            if (clr_stats) m_fails = 0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("receive_hshake", 32'(dpdm_if.receive_hshake), 32'((m_phase == 1 || m_phase == 2) && m_hs));
            chk("receive_data", 32'(dpdm_if.receive_data), 32'((m_phase == 1 || m_phase == 2) && !m_hs));
            chk("abort", 32'(dpdm_if.abort), 32'(m_phase == 4));
            chk("busy", 32'(busy), 32'(m_phase >= 1 && m_phase <= 4));
            chk("done", 32'(done), 32'(m_phase == 5));
            chk("fail_count", 32'(fail_count), 32'(m_fails));
            if (m_phase == 5) chk("result", 32'(result), 32'(m_code));
        end
    end

    task automatic run_chk_err(input bit clr_in_done);
        req_data = 1; step(); req_data = 0;
        step();
        dpdm_if.got_sync = 1; step(); dpdm_if.got_sync = 0;
        step();
        dpdm_if.end_rc_nrzi = 1; step(); dpdm_if.end_rc_nrzi = 0;
        chk_valid = 1; chk_ok = 0; step(); chk_valid = 0;
        dpdm_if.rc_dpdm_wait = 1; step(); dpdm_if.rc_dpdm_wait = 0;
        chk("t4_result", 32'(result), 32'(RC_CHK_ERR));
        clr_stats = clr_in_done;
        step();
        clr_stats = 0;
    endtask

    initial begin
        dpdm_if.got_sync = 0; dpdm_if.end_rc_nrzi = 0;
        dpdm_if.EOP_error = 0; dpdm_if.rc_dpdm_wait = 0;
        repeat (3) step();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_result", 32'(result), 32'(RC_OK));
        chk("rst_fail_count", 32'(fail_count), 0);
        chk("rst_receive", 32'({dpdm_if.receive_hshake, dpdm_if.receive_data, dpdm_if.abort}), 0);
        rst_n = 1;
        step();

        // 1: successful data receive
        req_data = 1; step(); req_data = 0;
        chk("t1_rd_c1", 32'(dpdm_if.receive_data), 1);
        repeat (9) step();
        dpdm_if.got_sync = 1; step(); dpdm_if.got_sync = 0;
        repeat (99) step();
        chk("t1_rd_c110", 32'(dpdm_if.receive_data), 1);
        dpdm_if.end_rc_nrzi = 1; step(); dpdm_if.end_rc_nrzi = 0;
        chk("t1_rd_c111", 32'(dpdm_if.receive_data), 0);
        step();
        chk_valid = 1; chk_ok = 1; step(); chk_valid = 0; chk_ok = 0;
        step();
        chk("t1_done_c114", 32'(done), 0);
        dpdm_if.rc_dpdm_wait = 1; step(); dpdm_if.rc_dpdm_wait = 0;
        chk("t1_done_c115", 32'(done), 1);
        chk("t1_result", 32'(result), 32'(RC_OK));
        step();
        chk("t1_fail_count", 32'(fail_count), 0);

        // 2: arm timeout
        req_hshake = 1; step(); req_hshake = 0;
        chk("t2_rh", 32'(dpdm_if.receive_hshake), 1);
        repeat (199) step();
        chk("t2_abort_c200", 32'(dpdm_if.abort), 0);
        step();
        chk("t2_abort_c201", 32'(dpdm_if.abort), 1);
        step();
        chk("t2_done_c202", 32'(done), 1);
        chk("t2_result", 32'(result), 32'(RC_TIMEOUT));
        step();
        chk("t2_fail_count", 32'(fail_count), 1);

        // 3: EOP error together with end of packet
        req_hshake = 1; step(); req_hshake = 0;
        repeat (2) step();
        dpdm_if.got_sync = 1; step(); dpdm_if.got_sync = 0;
        repeat (4) step();
        dpdm_if.EOP_error = 1; dpdm_if.end_rc_nrzi = 1; step();
        dpdm_if.EOP_error = 0; dpdm_if.end_rc_nrzi = 0;
        chk("t3_abort", 32'(dpdm_if.abort), 1);
        step();
        chk("t3_done", 32'(done), 1);
        chk("t3_result", 32'(result), 32'(RC_EOP_ERR));
        step();
        chk("t3_fail_count", 32'(fail_count), 2);

        // 4: checker errors saturate the counter; clr_stats wins over an increment
        for (int i = 0; i < 300; i++) run_chk_err(1'b0);
        chk("t4_saturated", 32'(fail_count), 255);
        clr_stats = 1; step(); clr_stats = 0;
        chk("t4_cleared", 32'(fail_count), 0);
        run_chk_err(1'b0);
        chk("t4_one", 32'(fail_count), 1);
        run_chk_err(1'b1);
        chk("t4_clr_beats_inc", 32'(fail_count), 0);

        // 5: cancel beats sync; request during DONE ignored
        req_data = 1; step(); req_data = 0;
        step();
        cancel = 1; dpdm_if.got_sync = 1; step(); cancel = 0; dpdm_if.got_sync = 0;
        chk("t5_abort", 32'(dpdm_if.abort), 1);
        step();
        chk("t5_done", 32'(done), 1);
        chk("t5_result", 32'(result), 32'(RC_CANCEL));
        req_data = 1; step(); req_data = 0;
        chk("t5_req_in_done", 32'(busy), 0);

        // 5b: request while busy ignored, then reset mid-body
        req_data = 1; step(); req_data = 0;
        dpdm_if.got_sync = 1; step(); dpdm_if.got_sync = 0;
        repeat (3) step();
        req_hshake = 1; step(); req_hshake = 0;
        chk("t5_busy_ignored", 32'(busy), 1);
        chk("t5_rd_held", 32'(dpdm_if.receive_data), 1);
        chk("t5_rh_low", 32'(dpdm_if.receive_hshake), 0);
        #2 rst_n = 0;
        #1;
        chk("t5_rst_outputs", 32'({dpdm_if.receive_hshake, dpdm_if.receive_data,
                                   dpdm_if.abort, busy, done}), 0);
        chk("t5_rst_fail_count", 32'(fail_count), 0);
        step(); step();
        rst_n = 1;
        step();
        chk("t5_after_rst_done", 32'(done), 0);
        chk("t5_after_rst_busy", 32'(busy), 0);
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rc_sequencer.md
Name: rc_sequencer

Overview:
Receive-side sequencer between the protocol FSM and rc_dpdm.
- Turns a one-cycle receive request (handshake or data) into the level-held receive_hshake/receive_data that rc_dpdm needs.
- Supervises sync, body, EOP and the downstream packet check (CRC/PID) with watchdog timers.
- Issues rc_dpdm's synchronous abort on timeout, error or cancel.
- Returns one result code per request and keeps a saturating failure counter.

Parameters:
- TMR_W, 8, width of the watchdog timer.
- ARM_TIMEOUT, 8'd200, clocks to wait for got_sync after arming.
- BODY_TIMEOUT, 8'd120, clocks from got_sync to end_rc_nrzi (more than 101 data bits).
- CHK_TIMEOUT, 8'd16, clocks from end_rc_nrzi to chk_valid plus rc_dpdm returning to WAIT.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- req_hshake  input  1  pulse: expect a handshake packet
- req_data  input  1  pulse: expect a data packet
- cancel  input  1  pulse: abandon the current receive
- clr_stats  input  1  pulse: clear fail_count
- got_sync  input  1  from rc_dpdm
- end_rc_nrzi  input  1  from rc_dpdm
- EOP_error  input  1  from rc_dpdm
- rc_dpdm_wait  input  1  from rc_dpdm, high while it is in WAIT
- chk_valid  input  1  pulse from the packet checker
- chk_ok  input  1  checker verdict, qualified by chk_valid
- receive_hshake  output  1  to rc_dpdm
- receive_data  output  1  to rc_dpdm
- abort  output  1  to rc_dpdm, one-cycle pulse
- busy  output  1  a request is in progress
- done  output  1  one-cycle result strobe
- result  output  3  rc_result_t, valid while done is high
- fail_count  output  8  saturating count of non-OK results

Behaviour:
Reset:
- State IDLE.
- All outputs 0; result = RC_OK; fail_count = 0; timer = 0.

Request acceptance:
- Requests are accepted only in IDLE and ignored otherwise.
- If req_hshake and req_data arrive together, req_hshake wins.
- On acceptance: latch kind (hs=1/0), clear timer, go ARM.

ARM:
- busy=1; receive_hshake=hs, receive_data=~hs, both held.
- Timer increments each clock.
- got_sync → RECV, timer cleared.
- Timer == ARM_TIMEOUT-1 with no sync → ABORT, code RC_TIMEOUT.

RECV:
- receive_* stay held so rc_dpdm can select its HS/DATA path on the sync cycle.
- end_rc_nrzi without EOP_error → CHECK, timer cleared, receive_* dropped.
- Timer == BODY_TIMEOUT-1 → ABORT, code RC_TIMEOUT.

CHECK:
- chk_valid latches chk_ok into a sticky flag.
- Once the flag is latched and rc_dpdm_wait=1 → DONE, code RC_OK if chk_ok else RC_CHK_ERR.
- Timer == CHK_TIMEOUT-1 → ABORT, code RC_TIMEOUT.

ABORT:
- abort=1 for exactly one cycle, then → DONE with the stored code.

DONE:
- done=1 and result driven for one cycle; busy=0.
- If result != RC_OK, fail_count increments, saturating at 8'hFF.
- Next state IDLE.
- A request arriving during DONE is ignored.

Priority within a cycle in ARM, RECV and CHECK (highest first):
1. cancel → ABORT, code RC_CANCEL.
2. EOP_error → ABORT, code RC_EOP_ERR. This also applies when EOP_error coincides with end_rc_nrzi.
3. Timeout.
4. Normal transitions.

Other rules:
- clr_stats zeroes fail_count. If it coincides with an increment, the result is 0.
- Watchdog timer is TMR_W bits, compared for equality and never wraps: the state always leaves before it can.
- rst_n asserted mid-operation returns to IDLE immediately with no done pulse. abort is not issued; rc_dpdm shares rst_n.

Decomposition:
- Package rc_pkg:
  - rc_result_t enum: RC_OK=0, RC_TIMEOUT=1, RC_EOP_ERR=2, RC_CHK_ERR=3, RC_CANCEL=4.
  - rc_seq_state_t: IDLE, ARM, RECV, CHECK, ABORT, DONE.
  - Default timeout constants.
- Sub-module rc_watchdog: clear/enable counter with a terminal-count compare. The timer uses it; fail_count stays inline.

Test Plan:
1. req_data; got_sync at cycle 10; end_rc_nrzi at cycle 110; chk_valid=1, chk_ok=1 at 112; rc_dpdm_wait=1 at 114 → done at 115 with RC_OK, receive_data high from cycle 1 to 110, fail_count=0.
2. req_hshake with no got_sync → abort pulses at cycle 201, done with RC_TIMEOUT at 202, fail_count=1.
3. req_hshake; got_sync; EOP_error and end_rc_nrzi in the same cycle → one abort cycle, then done with RC_EOP_ERR.
4. req_data; got_sync; end_rc_nrzi; chk_valid with chk_ok=0 → RC_CHK_ERR; repeat 300 times → fail_count saturates at 255; clr_stats → 0.
5. Cancel in the same cycle as got_sync → RC_CANCEL (cancel beats sync). Also: rst_n low mid-RECV → all outputs 0 with no done; a req_data pulse while busy is ignored.
